// File: rtl/icache.sv
// Blocking direct-mapped read-only instruction cache. Hits return in one cycle; misses refill a
// 16-byte line (or fetch one word when uncached) through the bridge read port.
module icache #(
   parameter int unsigned SETS = 64
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        valid,
   input  logic [31:0] addr,
   input  logic        uncached,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        rd_req,
   output logic [2:0]  rd_type,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data
);

   localparam int unsigned IW = $clog2(SETS);
   localparam int unsigned TW = 28 - IW;

   typedef enum logic [2:0] {StIdle, StLookup, StMiss, StRefill, StResp} state_e;

   state_e          state_q;
   logic [31:0]     req_addr_q;
   logic            req_unc_q;
   logic [1:0]      cnt_q;
   logic [31:0]     result_q;
   logic [SETS-1:0] valid_q;
   logic [TW-1:0]   tag_q  [SETS];
   logic [31:0]     data_q [SETS][4];

   logic [TW-1:0] req_tag;
   logic [IW-1:0] req_idx;
   logic [1:0]    req_off;
   logic          hit;
   logic          fill_beat;

   assign req_tag   = req_addr_q[31:4+IW];
   assign req_idx   = req_addr_q[4+IW-1:4];
   assign req_off   = req_addr_q[3:2];
   assign hit       = valid_q[req_idx] & (tag_q[req_idx] == req_tag) & ~req_unc_q;
   assign fill_beat = (state_q == StRefill) & ret_valid & ~req_unc_q;

   always_comb begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      rdata   = '0;
      rd_req  = 1'b0;
      rd_type = 3'b000;
      rd_addr = '0;
      case (state_q)
         StIdle:   addr_ok = 1'b1;
         StLookup: begin
            if (hit) begin
               addr_ok = 1'b1;
               data_ok = 1'b1;
               rdata   = data_q[req_idx][req_off];
            end
         end
         StMiss: begin
            rd_req  = 1'b1;
            rd_type = req_unc_q ? 3'b010 : 3'b100;
            rd_addr = req_unc_q ? req_addr_q : {req_addr_q[31:4], 4'b0000};
         end
         StResp: begin
            data_ok = 1'b1;
            rdata   = result_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= StIdle;
         req_addr_q <= '0;
         req_unc_q  <= 1'b0;
         cnt_q      <= 2'd0;
         result_q   <= '0;
         valid_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (valid) begin
                  req_addr_q <= addr;
                  req_unc_q  <= uncached;
                  state_q    <= StLookup;
               end
            end
            StLookup: begin
               if (!hit) begin
                  state_q <= StMiss;
               end else if (valid) begin
                  req_addr_q <= addr;
                  req_unc_q  <= uncached;
               end else begin
                  state_q <= StIdle;
               end
            end
            StMiss: begin
               if (rd_rdy) begin
                  cnt_q   <= 2'd0;
                  state_q <= StRefill;
               end
            end
            StRefill: begin
               if (ret_valid) begin
                  if (!req_unc_q) cnt_q <= cnt_q + 2'd1;
                  if (req_unc_q || cnt_q == req_off) result_q <= ret_data;
                  if (ret_last) begin
                     // The old line stays valid through the refill; only the tag flips here.
                     if (!req_unc_q) valid_q[req_idx] <= 1'b1;
                     state_q <= StResp;
                  end
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset && fill_beat) begin
         data_q[req_idx][cnt_q] <= ret_data;
         if (ret_last) tag_q[req_idx] <= req_tag;
      end
   end

endmodule

// File: doc/icache.md
# icache

Blocking, direct-mapped, read-only instruction cache between the IF stage and the AXI bridge's icache read port. It services hits in one cycle from register-based tag/valid/data arrays. On a miss it issues a 4-beat line refill, or a single-word read for uncached fetches, on the bridge's icache_req/icache_rd_rdy handshake. It then writes the returned beats into the line and returns the requested word to the core.

## Interface
- SETS, 64, number of lines; power of two; each line is 16 bytes (4 words). Index width IW = log2(SETS); tag = addr[31:4+IW].
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- valid  in  1  core fetch request
- addr  in  32  fetch address, word aligned
- uncached  in  1  bypass cache for this request; sampled with addr
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  rdata valid this cycle
- rdata  out  32  fetched instruction
- rd_req  out  1  refill request to bridge (icache_req)
- rd_type  out  3  3'b100 = 16-byte line, 3'b010 = single word (icache_type)
- rd_addr  out  32  refill address (icache_addr)
- rd_rdy  in  1  bridge accepts rd_req this cycle (icache_rd_rdy)
- ret_valid  in  1  return beat valid (icache_ret_valid)
- ret_last  in  1  final beat, qualified by ret_valid (icache_ret_last)
- ret_data  in  32  return beat data (icache_ret_data)

## Operation
- Request register latches addr, uncached, tag, index, offset=addr[3:2] on valid & addr_ok.
- States: IDLE, LOOKUP, MISS, REFILL, RESP.
- IDLE: addr_ok = 1. valid goes to LOOKUP.
- LOOKUP: hit = valid_bit[index] & tag_match & ~uncached.
  - On hit: data_ok = 1 and rdata = data[index][offset]. addr_ok = 1 in the same cycle. If valid, the request is accepted and the state stays LOOKUP with new request fields. Otherwise go to IDLE.
  - On miss or uncached: addr_ok = 0; go to MISS.
- MISS: rd_req = 1. Cached: rd_type = 3'b100, rd_addr = {tag, index, 4'b0}. Uncached: rd_type = 3'b010, rd_addr = request addr.
  - rd_req, rd_type and rd_addr are held stable until rd_req & rd_rdy, then go to REFILL with beat counter = 0.
- REFILL: each ret_valid beat:
  - Cached: write ret_data to data[index][counter], then counter += 1 (2-bit, wraps).
  - When counter == offset (cached), or on any beat (uncached), copy ret_data to the result register.
  - On ret_valid & ret_last: cached requests write tag[index] and set valid_bit[index] in that cycle; go to RESP.
  - Uncached requests never touch the arrays.
- RESP: data_ok = 1, rdata = result register; addr_ok = 0; go to IDLE.
- Replacement: a conflicting line (same index, different tag) is overwritten. Its valid bit stays 1 throughout the refill; the tag changes only on the last beat.
- A ret_valid outside REFILL is ignored.

## Timing
- Reset values: state = IDLE, all valid bits = 0, beat counter = 0, result register = 0. Outputs: addr_ok = 1 (IDLE), data_ok = 0, rd_req = 0, rd_type = 3'b000, rd_addr = 0, rdata = 0 when not data_ok.
- Hit: accept at T, data_ok at T+1. Back-to-back hits sustain 1 word/cycle.
- Miss: accept at T, LOOKUP at T+1, rd_req from T+2 until handshake H. The last beat L (ret_valid & ret_last) arrives at ≥ H+1. data_ok at L+1.
- The cache never asserts rd_req while in REFILL or RESP; only one refill is ever outstanding.
- areset at any cycle (including mid-REFILL): next cycle state = IDLE, all lines invalid, partial refill discarded. The bridge shares areset, so no stale beats follow.
- Hit on a just-filled line in the cycle after RESP+IDLE accept is legal; arrays are updated by then.

## Test plan
- Cold miss: reset; fetch 0x1C000008 cached; bridge returns 0x11,0x22,0x33,0x44 (last on 4th) -> rd_req with rd_type 3'b100, rd_addr 0x1C000000; data_ok one cycle after the last beat with rdata = 0x33.
- Hit streak: after the cold miss, fetch 0x1C000000, 0x1C000004, 0x1C00000C back-to-back -> data_ok on 3 consecutive cycles with 0x11, 0x22, 0x44; rd_req stays 0.
- Conflict: with SETS=64, fetch 0x1C000400 (same index 0, new tag) -> miss and refill; a following fetch of 0x1C000000 misses again.
- Uncached: fetch 0x1FE00000 with uncached=1; bridge returns 0xDEADBEEF with last -> rd_type 3'b010, rd_addr 0x1FE00000, rdata 0xDEADBEEF; a repeat cached fetch of the same address misses.
- rd_rdy stall: hold rd_rdy=0 for 5 cycles -> rd_req, rd_addr and rd_type stay constant; no state change.
- Reset mid-refill: assert areset after 2 of 4 beats -> next cycle addr_ok=1, data_ok=0; refetching the same line misses.
